// File: rtl/sha256_pkg.sv
// sha256_pkg
//   Shared SHA-256 definitions: round constants K, initial hash value IV,
//   the working-state type (eight 32-bit words a..h, index 0 = a), the
//   control FSM encodings and the bitwise helper functions used by the
//   round logic and the message schedule.
//   No ports (package).
package sha256_pkg;

  // Index 0 lands in the most significant 32 bits, so a flattened state
  // is already in digest byte order (H0 first).
  typedef logic [0:7][31:0] state_t;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_ROUNDS = 2'd1;
  localparam logic [1:0] ST_UPDATE = 2'd2;
  localparam logic [1:0] ST_OUTPUT = 2'd3;

  localparam state_t IV = {
    32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
    32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
  };

  localparam logic [31:0] K [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
    32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
    32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
    32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
    32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
    32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
    32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
    32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
    32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [31:0] ch(input logic [31:0] e, input logic [31:0] f,
                                     input logic [31:0] g);
    return (e & f) ^ (~e & g);
  endfunction

  function automatic logic [31:0] maj(input logic [31:0] a, input logic [31:0] b,
                                      input logic [31:0] c);
    return (a & b) ^ (a & c) ^ (b & c);
  endfunction

  function automatic logic [31:0] big_sigma0(input logic [31:0] x);
    return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
  endfunction

  function automatic logic [31:0] big_sigma1(input logic [31:0] x);
    return rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
  endfunction

  function automatic logic [31:0] small_sigma0(input logic [31:0] x);
    return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
  endfunction

  function automatic logic [31:0] small_sigma1(input logic [31:0] x);
    return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
  endfunction

endpackage

// File: rtl/sha256_round.sv
// sha256_round
//   Purely combinational single SHA-256 compression round.
//   Ports:
//     state_in   in  256  working variables a..h before the round
//     k          in  32   round constant K[t]
//     w          in  32   schedule word W[t]
//     state_out  out 256  working variables a..h after the round
module sha256_round
  import sha256_pkg::*;
(
  input  state_t      state_in,
  input  logic [31:0] k,
  input  logic [31:0] w,
  output state_t      state_out
);

  logic [31:0] t1;
  logic [31:0] t2;

  // Standard round: everything shifts down one slot, with a and e
  // receiving the freshly mixed values.
  always_comb begin
    t1 = state_in[7] + big_sigma1(state_in[4])
       + ch(state_in[4], state_in[5], state_in[6]) + k + w;
    t2 = big_sigma0(state_in[0]) + maj(state_in[0], state_in[1], state_in[2]);
    state_out[0] = t1 + t2;
    state_out[1] = state_in[0];
    state_out[2] = state_in[1];
    state_out[3] = state_in[2];
    state_out[4] = state_in[3] + t1;
    state_out[5] = state_in[4];
    state_out[6] = state_in[5];
    state_out[7] = state_in[6];
  end

endmodule

// File: rtl/sha256_stream_core.sv
// sha256_stream_core
//   SHA-256 engine for pre-padded messages. Rounds 0..15 execute as the
//   sixteen block words arrive; rounds 16..63 then run one per cycle, the
//   chaining value is updated, and after a message's final block the
//   32-byte digest is streamed out MSB first behind a one-cycle preamble.
//   Ports:
//     clk            in   1   rising-edge clock
//     reset          in   1   asynchronous, active-low reset
//     data           in   32  message word W[t], big-endian
//     write_enable   in   1   data valid this cycle
//     first_block    in   1   with word 0: start a new message (reload IV)
//     last_block     in   1   with word 0: emit digest after this block
//     busy           out  1   rounds 16..63 or chaining update in progress
//     digest         out  8   digest byte stream (8'h00 outside the window)
//     output_enable  out  1   33-cycle digest window (preamble + 32 bytes)
module sha256_stream_core
  import sha256_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] data,
  input  logic        write_enable,
  input  logic        first_block,
  input  logic        last_block,
  output logic        busy,
  output logic [7:0]  digest,
  output logic        output_enable
);

  logic [1:0]        fsm;
  logic [5:0]        rnd;
  logic [5:0]        out_cnt;
  state_t            h_reg;
  state_t            work;
  logic [0:15][31:0] w_win;
  logic              last_latched;
  logic [255:0]      out_shift;
  logic [7:0]        digest_reg;

  logic [31:0]       sched;
  logic [31:0]       w_t;
  state_t            round_in;
  state_t            round_out;
  state_t            h_sum;

  // w_win[15] holds W[t-1] and w_win[0] holds W[t-16]. While idle the
  // round consumes the incoming word directly; word 0 starts from either
  // the IV (new message) or the current chaining value.
  always_comb begin
    sched = small_sigma1(w_win[14]) + w_win[9] + small_sigma0(w_win[1]) + w_win[0];
    w_t = (fsm == ST_IDLE) ? data : sched;
    round_in = work;
    if (fsm == ST_IDLE && rnd == 6'd0) begin
      round_in = first_block ? IV : h_reg;
    end
    for (int i = 0; i < 8; i++) begin
      h_sum[i] = h_reg[i] + work[i];
    end
  end

  sha256_round u_round (
    .state_in  (round_in),
    .k         (K[rnd]),
    .w         (w_t),
    .state_out (round_out)
  );

  assign busy          = (fsm == ST_ROUNDS) || (fsm == ST_UPDATE);
  assign output_enable = (fsm == ST_OUTPUT);
  assign digest        = digest_reg;

  // rnd doubles as word counter while idle and round index afterwards; it
  // wraps from 63 back to 0 ready for the next block. The output shifter
  // is loaded with the new chaining value in the update cycle so the byte
  // stream needs no wide multiplexer.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fsm          <= ST_IDLE;
      rnd          <= '0;
      out_cnt      <= '0;
      h_reg        <= IV;
      work         <= '0;
      w_win        <= '0;
      last_latched <= 1'b0;
      out_shift    <= '0;
      digest_reg   <= 8'h00;
    end else begin
      case (fsm)
        ST_IDLE: begin
          if (write_enable) begin
            work  <= round_out;
            w_win <= {w_win[1:15], data};
            rnd   <= rnd + 6'd1;
            if (rnd == 6'd0) begin
              if (first_block) begin
                h_reg <= IV;
              end
              last_latched <= last_block;
            end
            if (rnd == 6'd15) begin
              fsm <= ST_ROUNDS;
            end
          end
        end
        ST_ROUNDS: begin
          work  <= round_out;
          w_win <= {w_win[1:15], sched};
          rnd   <= rnd + 6'd1;
          if (rnd == 6'd63) begin
            fsm <= ST_UPDATE;
          end
        end
        ST_UPDATE: begin
          h_reg      <= h_sum;
          out_shift  <= h_sum;
          out_cnt    <= '0;
          digest_reg <= 8'h00;
          fsm        <= last_latched ? ST_OUTPUT : ST_IDLE;
        end
        ST_OUTPUT: begin
          if (out_cnt == 6'd32) begin
            digest_reg <= 8'h00;
            fsm        <= ST_IDLE;
          end else begin
            digest_reg <= out_shift[255:248];
            out_shift  <= {out_shift[247:0], 8'h00};
            out_cnt    <= out_cnt + 6'd1;
          end
        end
        default: fsm <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sha256_stream_core.sv
// tb_sha256_stream_core
//   Directed bench for sha256_stream_core using known SHA-256 vectors
//   ("abc", empty message, 56 x '0'), writes during busy/output, async
//   reset mid-rounds and back-to-back messages.
module tb_sha256_stream_core;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] data = '0;
  logic        write_enable = 1'b0;
  logic        first_block = 1'b0;
  logic        last_block = 1'b0;
  logic        busy;
  logic [7:0]  digest;
  logic        output_enable;

  int passed = 0;
  int total  = 0;

  localparam logic [255:0] ABC_DIGEST =
    256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
  localparam logic [255:0] EMPTY_DIGEST =
    256'he3b0c44298fc1c149afbf4c8996fb92427ae41e4649b934ca495991b7852b855;
  localparam logic [255:0] ZEROS56_PART = {32'hbd03ac14, 192'h0, 32'h857ffc18};
  localparam logic [255:0] ZEROS56_MASK = {32'hffffffff, 192'h0, 32'hffffffff};
  localparam logic [255:0] FULL_MASK    = {256{1'b1}};

  logic [0:15][31:0] abc_blk;
  logic [0:15][31:0] empty_blk;
  logic [0:15][31:0] zeros_blk1;
  logic [0:15][31:0] zeros_blk2;

  sha256_stream_core dut (
    .clk           (clk),
    .reset         (reset),
    .data          (data),
    .write_enable  (write_enable),
    .first_block   (first_block),
    .last_block    (last_block),
    .busy          (busy),
    .digest        (digest),
    .output_enable (output_enable)
  );

  always #5 clk = ~clk;

  task automatic check_output(input string tag, input logic [255:0] obs,
                              input logic [255:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  // Drives one block on consecutive cycles. With noise set, first/last are
  // also raised on words 1..15, where the core must ignore them.
  task automatic apply_stimulus(input logic [0:15][31:0] words, input logic first,
                                input logic last, input logic noise);
    for (int i = 0; i < 16; i++) begin
      data         = words[i];
      write_enable = 1'b1;
      first_block  = (i == 0) ? first : noise;
      last_block   = (i == 0) ? last  : noise;
      @(posedge clk);
      #1;
    end
    write_enable = 1'b0;
    first_block  = 1'b0;
    last_block   = 1'b0;
    data         = '0;
  endtask

  // Called #1 after word 15 was taken: measures busy length, then either
  // collects the digest window or confirms no window opens.
  task automatic finish_block(input string tag, input logic junk, input logic expect_out,
                              input logic [255:0] exp_digest, input logic [255:0] mask);
    int busy_cycles = 0;
    int oe_cycles = 0;
    logic [255:0] got = '0;
    while (busy && busy_cycles < 100) begin
      busy_cycles++;
      if (junk) begin
        write_enable = 1'b1;
        data         = $urandom;
        first_block  = 1'b1;
        last_block   = 1'b1;
      end
      @(posedge clk);
      #1;
    end
    check_output({tag, "_busy_cycles"}, 256'(busy_cycles), 256'd49);
    if (expect_out) begin
      check_output({tag, "_window_open"}, 256'(output_enable), 256'd1);
      check_output({tag, "_preamble"}, 256'(digest), 256'd0);
      while (output_enable && oe_cycles < 40) begin
        if (oe_cycles >= 1) got = {got[247:0], digest};
        oe_cycles++;
        if (junk) begin
          write_enable = 1'b1;
          data         = $urandom;
        end
        @(posedge clk);
        #1;
      end
      write_enable = 1'b0;
      first_block  = 1'b0;
      last_block   = 1'b0;
      check_output({tag, "_window_len"}, 256'(oe_cycles), 256'd33);
      check_output({tag, "_digest"}, got & mask, exp_digest & mask);
    end else begin
      write_enable = 1'b0;
      first_block  = 1'b0;
      last_block   = 1'b0;
      check_output({tag, "_no_window"}, 256'(output_enable), 256'd0);
    end
    check_output({tag, "_idle_digest"}, 256'(digest), 256'd0);
    check_output({tag, "_idle_busy"}, 256'(busy), 256'd0);
  endtask

  initial begin
    abc_blk    = {32'h61626380, {14{32'h0}}, 32'h00000018};
    empty_blk  = {32'h80000000, {15{32'h0}}};
    zeros_blk1 = {{14{32'h30303030}}, 32'h80000000, 32'h0};
    zeros_blk2 = {{15{32'h0}}, 32'h000001c0};

    repeat (2) @(posedge clk);
    #1;
    check_output("reset_busy", 256'(busy), 256'd0);
    check_output("reset_oe", 256'(output_enable), 256'd0);
    check_output("reset_digest", 256'(digest), 256'd0);
    reset = 1'b1;
    @(posedge clk);
    #1;

    $display("[TB] single block abc");
    apply_stimulus(abc_blk, 1'b1, 1'b1, 1'b0);
    finish_block("abc", 1'b0, 1'b1, ABC_DIGEST, FULL_MASK);

    $display("[TB] two-block 56 x '0'");
    apply_stimulus(zeros_blk1, 1'b1, 1'b0, 1'b1);
    finish_block("zeros_b1", 1'b0, 1'b0, '0, '0);
    apply_stimulus(zeros_blk2, 1'b0, 1'b1, 1'b0);
    finish_block("zeros_b2", 1'b0, 1'b1, ZEROS56_PART, ZEROS56_MASK);

    $display("[TB] back-to-back abc reloads IV");
    apply_stimulus(abc_blk, 1'b1, 1'b1, 1'b0);
    finish_block("abc_again", 1'b0, 1'b1, ABC_DIGEST, FULL_MASK);

    $display("[TB] empty message with writes during busy and output");
    apply_stimulus(empty_blk, 1'b1, 1'b1, 1'b0);
    finish_block("empty_junk", 1'b1, 1'b1, EMPTY_DIGEST, FULL_MASK);

    $display("[TB] async reset mid-rounds");
    apply_stimulus(abc_blk, 1'b1, 1'b1, 1'b0);
    repeat (10) @(posedge clk);
    #3;
    check_output("pre_reset_busy", 256'(busy), 256'd1);
    reset = 1'b0;
    #1;
    check_output("async_reset_busy", 256'(busy), 256'd0);
    check_output("async_reset_oe", 256'(output_enable), 256'd0);
    check_output("async_reset_digest", 256'(digest), 256'd0);
    @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    apply_stimulus(empty_blk, 1'b1, 1'b1, 1'b0);
    finish_block("empty_after_reset", 1'b0, 1'b1, EMPTY_DIGEST, FULL_MASK);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
